vedic_mul32_seq: RTL and testbench

Sequential 32x32 unsigned multiplier that time-shares a single `vedic_16x16` instance across four partial products and accumulates them into a 64-bit result. It trades area for latency versus a fully parallel 32-bit Vedic tree. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/vedic_mul32_seq.sv | 136 +++++++++++++
 tb/tb_vedic_mul32_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul32_seq.sv
// Sequential 32x32 unsigned multiplier: one vedic_16x16 core is time-shared over
// four partial products that are accumulated into a 64-bit result.

module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] ll, lh, hl, hh;
  logic [8:0] mid;

  assign ll  = {4'b0, a[3:0]} * {4'b0, b[3:0]};
  assign lh  = {4'b0, a[3:0]} * {4'b0, b[7:4]};
  assign hl  = {4'b0, a[7:4]} * {4'b0, b[3:0]};
  assign hh  = {4'b0, a[7:4]} * {4'b0, b[7:4]};
  // Vertical/crosswise: the two cross products share one column weight.
  assign mid = {1'b0, lh} + {1'b0, hl};
  assign p   = {8'b0, ll} + {3'b0, mid, 4'b0} + {hh, 8'b0};
endmodule

module vedic_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [15:0] ll, lh, hl, hh;
  logic [16:0] mid;

  vedic_8x8 u_ll (.a(a[7:0]),  .b(b[7:0]),  .p(ll));
  vedic_8x8 u_lh (.a(a[7:0]),  .b(b[15:8]), .p(lh));
  vedic_8x8 u_hl (.a(a[15:8]), .b(b[7:0]),  .p(hl));
  vedic_8x8 u_hh (.a(a[15:8]), .b(b[15:8]), .p(hh));

  assign mid = {1'b0, lh} + {1'b0, hl};
  assign p   = {16'b0, ll} + {7'b0, mid, 8'b0} + {hh, 16'b0};
endmodule

module vedic_mul32_seq #(
  parameter int REG_PP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and in_ready/out_valid decode the state only.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] ar, br;
  logic [1:0]  cnt;
  logic [63:0] acc;
  logic [15:0] op_a, op_b;
  logic [31:0] pp;
  logic [31:0] pp_q;
  logic        pp_v;
  logic [1:0]  pp_sh;

  // Step 0: lo*lo, 1: lo*hi, 2: hi*lo, 3: hi*hi (a-half first).
  assign op_a = cnt[1] ? ar[31:16] : ar[15:0];
  assign op_b = cnt[0] ? br[31:16] : br[15:0];

  vedic_16x16 u_core (.a(op_a), .b(op_b), .p(pp));

  function automatic logic [63:0] align(input logic [31:0] prod, input logic [1:0] step);
    case (step)
      2'd0:    align = {32'b0, prod};
      2'd3:    align = {prod, 32'b0};
      default: align = {16'b0, prod, 16'b0};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ar    <= '0;
      br    <= '0;
      cnt   <= '0;
      acc   <= '0;
      pp_q  <= '0;
      pp_v  <= 1'b0;
      pp_sh <= '0;
    end else begin
      case (state)
        IDLE: begin
          pp_v <= 1'b0;
          if (in_valid) begin
            ar    <= a;
            br    <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          cnt <= cnt + 2'd1;
          if (REG_PP != 0) begin
            pp_q  <= pp;
            pp_v  <= 1'b1;
            pp_sh <= cnt;
            if (pp_v) acc <= acc + align(pp_q, pp_sh);
          end else begin
            acc <= acc + align(pp, cnt);
          end
          if (cnt == 2'd3) state <= (REG_PP != 0) ? DRAIN : DONE;
        end
        DRAIN: begin
          if (pp_v) acc <= acc + align(pp_q, pp_sh);
          pp_v  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DRAIN);
  assign y         = acc;
endmodule

// File: tb/tb_vedic_mul32_seq.sv
// Directed bench for vedic_mul32_seq: one instance per REG_PP setting, exercised
// in turn with corner products, back-pressure, back-to-back, reset abort and random traffic.

module tb_vedic_mul32_seq;
  logic        clk;
  logic [1:0]  rst_n;
  logic [31:0] a, b;
  logic [1:0]  in_valid, out_ready;
  logic        in_ready0, out_valid0, busy0;
  logic        in_ready1, out_valid1, busy1;
  logic [63:0] y0, y1;
  int          passed;
  int          total;

  vedic_mul32_seq #(.REG_PP(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .a(a), .b(b), .in_valid(in_valid[0]),
    .in_ready(in_ready0), .y(y0), .out_valid(out_valid0),
    .out_ready(out_ready[0]), .busy(busy0)
  );

  vedic_mul32_seq #(.REG_PP(1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .a(a), .b(b), .in_valid(in_valid[1]),
    .in_ready(in_ready1), .y(y1), .out_valid(out_valid1),
    .out_ready(out_ready[1]), .busy(busy1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] y_of(input int s);
    return (s != 0) ? y1 : y0;
  endfunction
  function automatic logic ir_of(input int s);
    return (s != 0) ? in_ready1 : in_ready0;
  endfunction
  function automatic logic ov_of(input int s);
    return (s != 0) ? out_valid1 : out_valid0;
  endfunction
  function automatic logic bz_of(input int s);
    return (s != 0) ? busy1 : busy0;
  endfunction

  task automatic check(input int s, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s (REG_PP=%0d): observed %h expected %h", tag, s, obs, exp);
  endtask

  // driver tasks: all start and end at posedge+1 with the DUT in IDLE
  task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input string tag);
    int cyc;
    a = av; b = bv; in_valid[s] = 1'b1;
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    cyc = 0;
    while (!ov_of(s) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(s, {tag, "_latency"}, 64'(cyc), 64'(4 + s));
    check(s, {tag, "_y"}, y_of(s), exp);
    out_ready[s] = 1'b1;
    @(posedge clk); #1;
    out_ready[s] = 1'b0;
    check(s, {tag, "_ready_after"}, {63'b0, ir_of(s)}, 64'd1);
  endtask

  task automatic back_pressure(input int s);
    int cyc;
    a = 32'h12345678; b = 32'h00000010; in_valid[s] = 1'b1;
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    cyc = 0;
    while (!ov_of(s) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(s, "bp_reach_done", {63'b0, ov_of(s)}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid[s] = i[0];
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check(s, "bp_y_hold", y_of(s), 64'h0000000123456780);
      check(s, "bp_in_ready_low", {63'b0, ir_of(s)}, 64'd0);
      check(s, "bp_out_valid_hold", {63'b0, ov_of(s)}, 64'd1);
    end
    in_valid[s] = 1'b0; out_ready[s] = 1'b1;
    @(posedge clk); #1;
    out_ready[s] = 1'b0;
    check(s, "bp_release_idle", {62'b0, ir_of(s), ov_of(s)}, 64'b10);
    run_op(s, 32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF, "bp_next");
  endtask

  task automatic back_to_back(input int s);
    logic [31:0] pa [3] = '{32'd7, 32'hFFFFFFFF, 32'h00010000};
    logic [31:0] pb [3] = '{32'd9, 32'd2,        32'h00010000};
    logic [63:0] pe [3] = '{64'd63, 64'h00000001FFFFFFFE, 64'h0000000100000000};
    int n_acc, n_out, last, cyc;
    logic hi, ho;
    logic [63:0] yv;
    n_acc = 0; n_out = 0; last = 0; cyc = 0;
    a = pa[0]; b = pb[0]; in_valid[s] = 1'b1; out_ready[s] = 1'b1;
    while (n_out < 3 && cyc < 60) begin
      hi = ir_of(s) && in_valid[s];
      ho = ov_of(s);
      yv = y_of(s);
      @(posedge clk); #1;
      cyc++;
      if (hi) begin
        n_acc++;
        if (n_acc < 3) begin a = pa[n_acc]; b = pb[n_acc]; end
        else in_valid[s] = 1'b0;
      end
      if (ho) begin
        check(s, "b2b_y", yv, pe[n_out]);
        if (n_out > 0) check(s, "b2b_spacing", 64'(cyc - last), 64'(6 + s));
        last = cyc;
        n_out++;
      end
    end
    in_valid[s] = 1'b0; out_ready[s] = 1'b0;
    check(s, "b2b_count", 64'(n_out), 64'd3);
  endtask

  task automatic reset_mid_op(input int s);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid[s] = 1'b1;
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check(s, "rst_busy_before", {63'b0, bz_of(s)}, 64'd1);
    #2 rst_n[s] = 1'b0;
    #1;
    check(s, "rst_async_flags", {61'b0, ir_of(s), ov_of(s), bz_of(s)}, 64'b100);
    check(s, "rst_async_y", y_of(s), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n[s] = 1'b1;
    @(posedge clk); #1;
    run_op(s, 32'd3, 32'd5, 64'd15, "rst_after");
  endtask

  task automatic random_traffic(input int s, input int n);
    logic [63:0] exp_q [$];
    int n_in, n_out, cyc;
    logic hi, ho;
    logic [63:0] yv;
    logic [31:0] av, bv;
    n_in = 0; n_out = 0; cyc = 0;
    while ((n_in < n || exp_q.size() > 0) && cyc < 8000) begin
      in_valid[s]  = (n_in < n) && ($urandom_range(0, 1) == 1);
      out_ready[s] = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom;
      hi = in_valid[s] && ir_of(s);
      ho = ov_of(s) && out_ready[s];
      yv = y_of(s); av = a; bv = b;
      @(posedge clk); #1;
      cyc++;
      if (hi) begin
        exp_q.push_back({32'b0, av} * {32'b0, bv});
        n_in++;
      end
      if (ho) begin
        n_out++;
        if (exp_q.size() > 0) check(s, "rand_y", yv, exp_q.pop_front());
      end
    end
    in_valid[s] = 1'b0; out_ready[s] = 1'b0;
    check(s, "rand_inputs", 64'(n_in), 64'(n));
    check(s, "rand_out_count", 64'(n_out), 64'(n_in));
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 2'b00; in_valid = 2'b00; out_ready = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 2'b11;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      check(s, "reset_flags", {61'b0, ir_of(s), ov_of(s), bz_of(s)}, 64'b100);
      check(s, "reset_y", y_of(s), 64'd0);
    end
    for (int s = 0; s < 2; s++) begin
      run_op(s, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "max_max");
      run_op(s, 32'h0000FFFF, 32'hFFFF0000, 64'h0000FFFE00010000, "lo_hi");
      run_op(s, 32'h80000000, 32'd2,        64'h0000000100000000, "msb_x2");
      run_op(s, 32'd0,        32'h12345678, 64'd0,                "zero");
      run_op(s, 32'hFFFF0000, 32'hFFFF0000, 64'hFFFE000100000000, "hi_hi");
      back_pressure(s);
      back_to_back(s);
      reset_mid_op(s);
      random_traffic(s, 150);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
